weight_stream_tx: RTL and testbench

//  Transmit end of the weight-load channel into the horizontal weight buffer of the 32x32 PE array.

---
 rtl/weight_stream_tx.sv | 128 ++++++++++++
 tb/tb_weight_stream_tx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_stream_tx.sv
// Weight-load transmitter: streams GLB words into the PE-array weight buffer in fill order,
// with a 2-entry prefetch FIFO and restart-from-word-0 whenever the buffer drops ready_w.
module weight_stream_tx #(
  parameter int DATA_W     = 32,
  parameter int ROW_NUM    = 32,
  parameter int GLB_ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            pass_layer_type,
  input  logic [5:0]            row_en,
  input  logic [4:0]            col_in,
  input  logic [GLB_ADDR_W-1:0] base_addr,
  output logic                  glb_re,
  output logic [GLB_ADDR_W-1:0] glb_addr,
  input  logic [DATA_W-1:0]     glb_rdata,
  output logic                  change_weight_f,
  output logic                  valid_w,
  input  logic                  ready_w,
  output logic [DATA_W-1:0]     weight_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, CLEAR, STREAM, FIN} state_t;

  state_t                  state, state_nx;
  logic [8:0]              n_words;
  logic [8:0]              rd_idx;
  logic [8:0]              xfer_cnt;
  logic [GLB_ADDR_W-1:0]   base_q;
  logic                    err_q;
  logic                    rd_pend;
  logic [DATA_W-1:0]       fifo_mem [2];
  logic                    fifo_rp, fifo_wp;
  logic [1:0]              fifo_cnt;

  logic                    cfg_ok;
  logic [3:0]              words_per_row;
  logic [8:0]              n_calc;
  logic                    in_stream, rewind, xfer, push, pop, fifo_empty;
  logic [2:0]              pending;
  logic                    unused_bits;

  assign unused_bits   = ^col_in[1:0];
  assign cfg_ok        = (pass_layer_type < 2'd2) && (row_en != 6'd0) && (row_en <= 6'(ROW_NUM));
  assign words_per_row = {1'b0, col_in[4:2]} + 4'd1;
  assign n_calc        = (pass_layer_type == 2'd0) ? ({3'b0, row_en} * {5'b0, words_per_row})
                                                   : {3'b0, row_en};

  assign in_stream  = (state == STREAM);
  assign rewind     = in_stream && !ready_w;
  assign fifo_empty = (fifo_cnt == 2'd0);
  // A word returning from the GLB this cycle counts as available; it bypasses storage if popped at once.
  assign valid_w    = in_stream && (!fifo_empty || rd_pend);
  assign weight_in  = !valid_w ? '0 : (fifo_empty ? glb_rdata : fifo_mem[fifo_rp]);
  assign xfer       = valid_w && ready_w;
  assign pop        = xfer && !fifo_empty;
  assign push       = in_stream && ready_w && rd_pend && !(xfer && fifo_empty);
  assign pending    = {1'b0, fifo_cnt} + {2'b0, rd_pend};

  assign glb_re          = (state == CLEAR) ||
                           (in_stream && ready_w && (rd_idx < n_words) && (pending < 3'd2));
  assign glb_addr        = glb_re ? (base_q + GLB_ADDR_W'(rd_idx)) : '0;
  assign change_weight_f = (state == CLEAR);
  assign busy            = (state == CLEAR) || in_stream;
  assign done            = (state == FIN);
  assign err             = (state == FIN) && err_q;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = cfg_ok ? CLEAR : FIN;
      CLEAR:   state_nx = STREAM;
      STREAM:  if (xfer && (xfer_cnt == n_words - 9'd1)) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      n_words  <= '0;
      base_q   <= '0;
      err_q    <= 1'b0;
      rd_idx   <= '0;
      xfer_cnt <= '0;
      rd_pend  <= 1'b0;
      fifo_rp  <= 1'b0;
      fifo_wp  <= 1'b0;
      fifo_cnt <= '0;
    end else begin
      state   <= state_nx;
      rd_pend <= glb_re;
      if (state == IDLE && start) begin
        err_q    <= !cfg_ok;
        n_words  <= n_calc;
        base_q   <= base_addr;
        rd_idx   <= '0;
        xfer_cnt <= '0;
        fifo_rp  <= 1'b0;
        fifo_wp  <= 1'b0;
        fifo_cnt <= '0;
      end else if (rewind) begin
        // Buffer dropped its pointer: forget everything fetched so far and refetch from word 0.
        rd_idx   <= '0;
        xfer_cnt <= '0;
        fifo_rp  <= 1'b0;
        fifo_wp  <= 1'b0;
        fifo_cnt <= '0;
      end else begin
        if (glb_re) rd_idx <= rd_idx + 9'd1;
        if (xfer)   xfer_cnt <= xfer_cnt + 9'd1;
        if (push)   fifo_wp <= ~fifo_wp;
        if (pop)    fifo_rp <= ~fifo_rp;
        fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[fifo_wp] <= glb_rdata;
  end

endmodule

// File: tb/tb_weight_stream_tx.sv
// Bench for weight_stream_tx: GLB memory model, transaction-level reference model and
// per-cycle compare, directed loads with literal expectations, then randomized loads.
module tb_weight_stream_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  pass_layer_type;
  logic [5:0]  row_en;
  logic [4:0]  col_in;
  logic [15:0] base_addr;
  logic        glb_re;
  logic [15:0] glb_addr;
  logic [31:0] glb_rdata;
  logic        change_weight_f;
  logic        valid_w;
  logic        ready_w;
  logic [31:0] weight_in;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  weight_stream_tx #(.DATA_W(32), .ROW_NUM(32), .GLB_ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .pass_layer_type(pass_layer_type),
    .row_en(row_en), .col_in(col_in), .base_addr(base_addr), .glb_re(glb_re),
    .glb_addr(glb_addr), .glb_rdata(glb_rdata), .change_weight_f(change_weight_f),
    .valid_w(valid_w), .ready_w(ready_w), .weight_in(weight_in), .busy(busy),
    .done(done), .err(err)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // GLB contents: the 0xA0000000+a pattern when salt is 0, otherwise a salted hash.
  logic [31:0] salt = 32'h0;
  function automatic logic [31:0] glb_word(input logic [15:0] a);
    if (salt == 32'h0) return 32'hA000_0000 + {16'h0, a};
    return ({16'h0, a} * 32'h9E37_79B1) ^ salt;
  endfunction

  always @(posedge clk) glb_rdata <= glb_re ? glb_word(glb_addr) : $urandom;

  // Reference model state (transaction level: expected word index and read index).
  int          phase = 0;   // 0 idle, 1 clear cycle, 2 streaming, 3 completion cycle
  int          m_n, k, rd_next, since_low, cyc;
  logic [15:0] m_base;
  logic        m_err;
  logic [31:0] xq[$];
  logic [15:0] rq[$];
  int          done_cyc, cwf_cnt, done_cnt;
  logic        done_err;
  bit          load_done;

  function automatic bit legal(input logic [1:0] t, input logic [5:0] r);
    return (t < 2) && (r != 0) && (r <= 32);
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      check("rst_ctrl", {26'h0, glb_re, change_weight_f, valid_w, busy, done, err}, 32'h0);
      check("rst_data", {glb_addr, 16'h0} | weight_in, 32'h0);
      phase = 0;
    end else begin
      cyc++;
      case (phase)
        0: begin
          check("idle_outs", {27'h0, glb_re, change_weight_f, valid_w, busy, done}, 32'h0);
          if (start) begin
            cyc = 0; xq.delete(); rq.delete(); cwf_cnt = 0; done_cnt = 0;
            m_base = base_addr;
            m_n = (pass_layer_type == 0) ? int'(row_en) * (int'(col_in[4:2]) + 1) : int'(row_en);
            if (legal(pass_layer_type, row_en)) phase = 1;
            else begin phase = 3; m_err = 1'b1; end
          end
        end
        1: begin
          check("clear_outs", {27'h0, change_weight_f, glb_re, busy, valid_w, done}, 32'h1C);
          check("clear_addr", {16'h0, glb_addr}, {16'h0, m_base});
          rq.push_back(glb_addr);
          cwf_cnt++; rd_next = 1; k = 0; since_low = 2; phase = 2;
        end
        2: begin
          check("stream_ctrl", {29'h0, busy, change_weight_f, done}, 32'h4);
          check("stream_valid", {31'h0, valid_w}, {31'h0, since_low >= 2});
          if (glb_re) begin
            check("read_addr", {16'h0, glb_addr}, {16'h0, m_base + 16'(rd_next)});
            check("read_in_range", {31'h0, rd_next < m_n}, 32'h1);
            rq.push_back(glb_addr);
            rd_next++;
          end
          if (valid_w && ready_w) begin
            check("word", weight_in, glb_word(m_base + 16'(k)));
            xq.push_back(weight_in);
            k++;
            if (k == m_n) begin phase = 3; m_err = 1'b0; end
          end
          if (!ready_w) begin
            k = 0; rd_next = 0; since_low = 1;
          end else since_low++;
        end
        default: begin
          check("fin_outs", {26'h0, done, err, busy, valid_w, glb_re, change_weight_f},
                {26'h0, 1'b1, m_err, 4'h0});
          done_cyc = cyc; done_err = err; done_cnt++; load_done = 1'b1; phase = 0;
        end
      endcase
    end
  end

  // mode 0: ready always high; 1: up to 3 random drops; 2: low 2 cycles after 5 transfers
  task automatic run_load(input logic [1:0] t, input logic [5:0] r, input logic [4:0] c,
                          input logic [15:0] b, input int mode, input bit busy_starts);
    int  drops = 0;
    int  low_left = 0;
    bit  dropped = 0;
    bit  finished = 0;
    @(posedge clk); #1;
    load_done = 1'b0;
    pass_layer_type = t; row_en = r; col_in = c; base_addr = b; ready_w = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pass_layer_type = 2'($urandom); row_en = 6'($urandom); col_in = 5'($urandom);
    base_addr = 16'($urandom);
    for (int i = 0; i < 3000; i++) begin
      if (load_done) begin finished = 1; break; end
      if (mode == 1) begin
        if (drops < 3 && $urandom_range(0, 15) == 0) begin ready_w = 1'b0; drops++; end
        else ready_w = 1'b1;
      end else if (mode == 2) begin
        if (xq.size() == 5 && !dropped) begin low_left = 2; dropped = 1; end
        ready_w = (low_left == 0);
        if (low_left > 0) low_left--;
      end else ready_w = 1'b1;
      start = busy_starts && ($urandom_range(0, 9) == 0);
      @(posedge clk); #1;
    end
    start = 1'b0; ready_w = 1'b1;
    if (!finished) check("load_timeout", 32'h0, 32'h1);
  endtask

  task automatic check_test1(input string tag);
    check({tag, "_done_cyc"}, done_cyc, 18);
    check({tag, "_err"}, {31'h0, done_err}, 32'h0);
    check({tag, "_nwords"}, xq.size(), 16);
    if (xq.size() == 16) begin
      check({tag, "_first"}, xq[0], 32'hA000_0010);
      check({tag, "_last"}, xq[15], 32'hA000_001F);
    end
    check({tag, "_cwf_cnt"}, cwf_cnt, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pass_layer_type = 2'd0; row_en = 6'd0; col_in = 5'd0;
    base_addr = 16'h0; ready_w = 1'b1;
    #1;
    check("por_ctrl", {26'h0, glb_re, change_weight_f, valid_w, busy, done, err}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1 reset = 1'b0;

    // 1: PW, 2 rows x 8 words
    salt = 32'h0;
    run_load(2'd0, 6'd2, 5'd31, 16'h0010, 0, 0);
    check_test1("t1");

    // 2: DW, 30 rows
    run_load(2'd1, 6'd30, 5'd0, 16'h0100, 0, 0);
    check("t2_done_cyc", done_cyc, 32);
    check("t2_nwords", xq.size(), 30);
    check("t2_nreads", rq.size(), 30);
    if (rq.size() == 30) check("t2_last_read", {16'h0, rq[29]}, 32'h11D);

    // 3: address wrap
    run_load(2'd0, 6'd1, 5'd7, 16'hFFFF, 0, 0);
    check("t3_done_cyc", done_cyc, 4);
    check("t3_nreads", rq.size(), 2);
    if (rq.size() == 2) begin
      check("t3_read0", {16'h0, rq[0]}, 32'hFFFF);
      check("t3_read1", {16'h0, rq[1]}, 32'h0000);
    end

    // 4: rewind after 5 transfers
    run_load(2'd0, 6'd2, 5'd31, 16'h0010, 2, 0);
    check("t4_nxfers", xq.size(), 21);
    if (xq.size() == 21) begin
      check("t4_restart", xq[5], 32'hA000_0010);
      check("t4_last", xq[20], 32'hA000_001F);
    end
    check("t4_cwf_cnt", cwf_cnt, 1);
    check("t4_done_cnt", done_cnt, 1);
    check("t4_done_cyc", done_cyc, 26);

    // 5: illegal configs
    run_load(2'd2, 6'd4, 5'd0, 16'h0, 0, 0);
    check("t5a_done_cyc", done_cyc, 1);
    check("t5a_err", {31'h0, done_err}, 32'h1);
    check("t5a_quiet", rq.size() + xq.size() + cwf_cnt, 0);
    run_load(2'd0, 6'd0, 5'd0, 16'h0, 0, 0);
    check("t5b_done_cyc", done_cyc, 1);
    check("t5b_err", {31'h0, done_err}, 32'h1);
    check("t5b_quiet", rq.size() + xq.size() + cwf_cnt, 0);

    // 6: reset in the middle of streaming
    @(posedge clk); #1;
    pass_layer_type = 2'd0; row_en = 6'd2; col_in = 5'd31; base_addr = 16'h0010; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("t6_async_ctrl", {26'h0, glb_re, change_weight_f, valid_w, busy, done, err}, 32'h0);
    check("t6_async_data", {glb_addr, 16'h0} | weight_in, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    check("t6_no_done", done_cnt, 0);
    run_load(2'd0, 6'd2, 5'd31, 16'h0010, 0, 0);
    check_test1("t6");

    // randomized loads with ready drops and starts while busy
    for (int n = 0; n < 30; n++) begin
      logic [1:0] t;
      logic [5:0] r;
      salt = $urandom | 32'h1;
      t = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      r = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 40)) : 6'($urandom_range(1, 32));
      run_load(t, r, 5'($urandom), 16'($urandom), 1, 1);
      check("rand_err", {31'h0, done_err}, {31'h0, !legal(t, r)});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
